// File: rtl/leaf_interface_0_pkg.sv
// Shared definitions for the leaf endpoint: packet sizing and drop-counter helpers.
// Packet layout is {valid, dest_addr, payload} with valid at the MSB.
package leaf_interface_0_pkg;

  localparam int          DROP_CNT_W   = 16;
  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  function automatic int pkt_width(input int addr_w, input int pay_w);
    return 1 + addr_w + pay_w;
  endfunction

  // Saturating increment so a long overflow burst never wraps back to a small count.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == DROP_CNT_MAX) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/leaf_interface_0_fifo.sv
// Synchronous show-ahead FIFO with wrap-flag pointers; a push while full is
// accepted only when a pop happens on the same edge.
module sync_fifo_0 #(
  parameter int data_width = 8,
  parameter int depth      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [data_width-1:0] i_data,
  input  logic                  i_pop,
  output logic [data_width-1:0] o_head,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int PW = $clog2(depth);

  logic [PW:0]           r_wr_ptr;
  logic [PW:0]           r_rd_ptr;
  logic [data_width-1:0] r_mem [depth];
  logic                  w_wr_en;
  logic                  w_rd_en;

  assign o_full  = (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]) && (r_wr_ptr[PW] != r_rd_ptr[PW]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign w_wr_en = i_push && (!o_full || i_pop);
  assign w_rd_en = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr[PW-1:0]];

  // Pointer update; the extra MSB makes full and empty distinguishable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= {(PW+1){1'b0}};
      r_rd_ptr <= {(PW+1){1'b0}};
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + {{PW{1'b0}}, 1'b1};
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + {{PW{1'b0}}, 1'b1};
    end
  end

  // Storage is left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
  end

endmodule

// File: rtl/leaf_interface_0.sv
// Leaf endpoint of the butterfly-fat-tree network: tx stream -> bus_o, bus_i -> rx stream.
// Define LEAF_DROP_CNT_EN to add drop_cnt_o, a saturating count of rx-full drops.
module leaf_interface_0
  import leaf_interface_0_pkg::*;
#(
  parameter int num_leaves = 2,
  parameter int payload_sz = 32,
  parameter int addr       = 0,
  parameter int fifo_depth = 8,
  localparam int aw        = $clog2(num_leaves),
  parameter int p_sz       = pkt_width($clog2(num_leaves), payload_sz)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [payload_sz-1:0] din,
  input  logic [aw-1:0]         din_dest,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [p_sz-1:0]       bus_o,
  input  logic [p_sz-1:0]       bus_i,
  output logic [payload_sz-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  misroute_o
`ifdef LEAF_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
`endif
);

  localparam int          VLD_BIT  = p_sz - 1;
  localparam int          ADDR_LSB = payload_sz;
  localparam logic [aw-1:0] MY_ADDR = aw'(addr);

  logic                     w_tx_full;
  logic                     w_tx_empty;
  logic                     w_tx_push;
  logic [aw+payload_sz-1:0] w_tx_head;
  logic                     w_rx_full;
  logic                     w_rx_empty;
  logic                     w_rx_hit;
  logic                     w_rx_miss;
  logic                     w_rx_pop;
  logic [p_sz-1:0]          r_rx_q;

  assign din_ready = !w_tx_full;
  assign w_tx_push = din_valid && !w_tx_full;

  sync_fifo_0 #(.data_width(aw + payload_sz), .depth(fifo_depth)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_tx_push),
    .i_data  ({din_dest, din}),
    .i_pop   (!w_tx_empty),
    .o_head  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  // Inject one packet per cycle while tx has data; an idle link carries all zeros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_o <= {p_sz{1'b0}};
    end else if (!w_tx_empty) begin
      bus_o <= {1'b1, w_tx_head};
    end else begin
      bus_o <= {p_sz{1'b0}};
    end
  end

  // Input capture stage from the switch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_q <= {p_sz{1'b0}};
    end else begin
      r_rx_q <= bus_i;
    end
  end

  assign w_rx_hit   = r_rx_q[VLD_BIT] && (r_rx_q[ADDR_LSB +: aw] == MY_ADDR);
  assign w_rx_miss  = r_rx_q[VLD_BIT] && (r_rx_q[ADDR_LSB +: aw] != MY_ADDR);
  assign dout_valid = !w_rx_empty;
  assign w_rx_pop   = dout_valid && dout_ready;

  sync_fifo_0 #(.data_width(payload_sz), .depth(fifo_depth)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_rx_hit),
    .i_data  (r_rx_q[payload_sz-1:0]),
    .i_pop   (w_rx_pop),
    .o_head  (dout),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // Misroute flag is sticky until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misroute_o <= 1'b0;
    end else if (w_rx_miss) begin
      misroute_o <= 1'b1;
    end else begin
      misroute_o <= misroute_o;
    end
  end

`ifdef LEAF_DROP_CNT_EN
  logic w_rx_drop;
  assign w_rx_drop = w_rx_hit && w_rx_full && !w_rx_pop;

  // Count packets discarded because the rx queue was full with no pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_o <= 16'h0000;
    end else if (w_rx_drop) begin
      drop_cnt_o <= sat_inc16(drop_cnt_o);
    end else begin
      drop_cnt_o <= drop_cnt_o;
    end
  end
`endif

endmodule

// File: tb/tb_leaf_interface_0.sv
// Directed self-checking bench for leaf_interface_0 (num_leaves=2, addr=0, depth 8).
module tb_leaf_interface_0;

  localparam int PAY  = 32;
  localparam int AW   = 1;
  localparam int P_SZ = 1 + AW + PAY;

  logic            clk;
  logic            reset;
  logic [PAY-1:0]  din;
  logic [AW-1:0]   din_dest;
  logic            din_valid;
  logic            din_ready;
  logic [P_SZ-1:0] bus_o;
  logic [P_SZ-1:0] bus_i;
  logic [PAY-1:0]  dout;
  logic            dout_valid;
  logic            dout_ready;
  logic            misroute_o;
`ifdef LEAF_DROP_CNT_EN
  logic [15:0]     drop_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  leaf_interface_0 #(.num_leaves(2), .payload_sz(PAY), .addr(0), .fifo_depth(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_dest   (din_dest),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .bus_o      (bus_o),
    .bus_i      (bus_i),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .misroute_o (misroute_o)
`ifdef LEAF_DROP_CNT_EN
    ,
    .drop_cnt_o (drop_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; din = '0; din_dest = '0; din_valid = 1'b0; bus_i = '0; dout_ready = 1'b0;
    #12;
    checks++; if (bus_o !== '0) begin errors++; $display("FAIL reset_bus_o got %h want 0", bus_o); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready got %b want 1", din_ready); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got %b want 0", dout_valid); end
    checks++; if (misroute_o !== 1'b0) begin errors++; $display("FAIL reset_misroute got %b want 0", misroute_o); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_tx_single();
    din = 32'hA5A5_0001; din_dest = 1'b1; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    checks++; if (bus_o !== '0) begin errors++; $display("FAIL tx_single_edge0 got %h want 0", bus_o); end
    step();
    checks++; if (bus_o !== {1'b1, 1'b1, 32'hA5A5_0001}) begin errors++; $display("FAIL tx_single_edge1 got %h want %h", bus_o, {1'b1, 1'b1, 32'hA5A5_0001}); end
    step();
    checks++; if (bus_o !== '0) begin errors++; $display("FAIL tx_single_idle got %h want 0", bus_o); end
  endtask

  task automatic test_tx_fill();
    logic [P_SZ-1:0] exp;
    for (int cyc = 0; cyc <= 8; cyc++) begin
      if (cyc < 8) begin
        din = 32'h0000_0100 + 32'(cyc); din_dest = 1'(cyc); din_valid = 1'b1;
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL tx_fill_ready cyc=%0d got %b want 1", cyc, din_ready); end
      end else begin
        din_valid = 1'b0;
      end
      step();
      if (cyc >= 1) begin
        exp = {1'b1, 1'(cyc - 1), 32'h0000_0100 + 32'(cyc - 1)};
        checks++; if (bus_o !== exp) begin errors++; $display("FAIL tx_fill_pkt%0d got %h want %h", cyc - 1, bus_o, exp); end
      end
    end
    step();
    checks++; if (bus_o !== '0) begin errors++; $display("FAIL tx_fill_idle got %h want 0", bus_o); end
  endtask

  task automatic test_rx_inorder();
    dout_ready = 1'b1;
    bus_i = {1'b1, 1'b0, 32'd1};
    step();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rx_early_valid got %b want 0", dout_valid); end
    bus_i = {1'b1, 1'b0, 32'd2};
    step();
    checks++; if (dout_valid !== 1'b1 || dout !== 32'd1) begin errors++; $display("FAIL rx_inorder_1 got v=%b d=%h want v=1 d=1", dout_valid, dout); end
    bus_i = {1'b1, 1'b0, 32'd3};
    step();
    checks++; if (dout_valid !== 1'b1 || dout !== 32'd2) begin errors++; $display("FAIL rx_inorder_2 got v=%b d=%h want v=1 d=2", dout_valid, dout); end
    bus_i = '0;
    step();
    checks++; if (dout_valid !== 1'b1 || dout !== 32'd3) begin errors++; $display("FAIL rx_inorder_3 got v=%b d=%h want v=1 d=3", dout_valid, dout); end
    step();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rx_inorder_drain got %b want 0", dout_valid); end
  endtask

  task automatic test_rx_overflow();
    logic [PAY-1:0] exp;
    dout_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus_i = {1'b1, 1'b0, 32'h10 + 32'(i)};
      step();
    end
    bus_i = '0;
    step();
    step();
    checks++; if (dout_valid !== 1'b1 || dout !== 32'h10) begin errors++; $display("FAIL rx_ovf_head got v=%b d=%h want v=1 d=10", dout_valid, dout); end
`ifdef LEAF_DROP_CNT_EN
    checks++; if (drop_cnt_o !== 16'd2) begin errors++; $display("FAIL rx_ovf_drops got %0d want 2", drop_cnt_o); end
`endif
    bus_i = {1'b1, 1'b0, 32'h55};
    step();
    bus_i = '0; dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    checks++; if (dout !== 32'h11) begin errors++; $display("FAIL rx_full_pushpop got %h want 11", dout); end
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 32'h11 + 32'(i) : 32'h55;
      checks++; if (dout_valid !== 1'b1 || dout !== exp) begin errors++; $display("FAIL rx_ovf_drain%0d got v=%b d=%h want v=1 d=%h", i, dout_valid, dout, exp); end
      step();
    end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rx_ovf_empty got %b want 0", dout_valid); end
`ifdef LEAF_DROP_CNT_EN
    checks++; if (drop_cnt_o !== 16'd2) begin errors++; $display("FAIL rx_ovf_drops_after got %0d want 2", drop_cnt_o); end
`endif
    dout_ready = 1'b0;
  endtask

  task automatic test_misroute();
    bus_i = {1'b1, 1'b1, 32'hDEAD_BEEF};
    step();
    bus_i = '0;
    checks++; if (misroute_o !== 1'b0) begin errors++; $display("FAIL misroute_early got %b want 0", misroute_o); end
    step();
    checks++; if (misroute_o !== 1'b1) begin errors++; $display("FAIL misroute_set got %b want 1", misroute_o); end
    step();
    checks++; if (misroute_o !== 1'b1 || dout_valid !== 1'b0) begin errors++; $display("FAIL misroute_sticky got m=%b v=%b want m=1 v=0", misroute_o, dout_valid); end
  endtask

  task automatic test_async_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_i = {1'b1, 1'b0, 32'h70 + 32'(i)};
      din = 32'h80 + 32'(i); din_dest = 1'b1; din_valid = 1'b1;
      step();
    end
    bus_i = '0;
    step();
    checks++; if (bus_o[P_SZ-1] !== 1'b1 || dout_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got bv=%b dv=%b want 1 1", bus_o[P_SZ-1], dout_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus_o !== '0) begin errors++; $display("FAIL async_bus_o got %h want 0", bus_o); end
    checks++; if (dout_valid !== 1'b0 || din_ready !== 1'b1 || misroute_o !== 1'b0) begin errors++; $display("FAIL async_flags got dv=%b dr=%b m=%b want 0 1 0", dout_valid, din_ready, misroute_o); end
`ifdef LEAF_DROP_CNT_EN
    checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL async_drops got %0d want 0", drop_cnt_o); end
`endif
    din_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    step();
    checks++; if (dout_valid !== 1'b0 || din_ready !== 1'b1 || bus_o !== '0) begin errors++; $display("FAIL post_reset got dv=%b dr=%b bus=%h want 0 1 0", dout_valid, din_ready, bus_o); end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_tx_fill();
    test_rx_inorder();
    test_rx_overflow();
    test_misroute();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
